// File: rtl/udp_ip_pkg.sv
// Shared definitions for the UDP/IPv4 receive and transmit stacks.
// Field constants, header word indices and the parser state encoding.
package udp_ip_pkg;

    typedef enum logic [1:0] {
        StHdr,
        StUdp,
        StPayload,
        StDrop
    } state_e;

    localparam logic [3:0]  IP_VERSION   = 4'd4;
    localparam logic [3:0]  IP_IHL_MIN   = 4'd5;
    localparam logic [7:0]  IP_PROTO_UDP = 8'd17;

    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam logic [15:0] IP_HDR_BYTES  = 16'd20;
    localparam logic [15:0] IP_MIN_TOTAL  = IP_HDR_BYTES + UDP_HDR_BYTES;

    localparam logic [2:0] HDR_WORD_VER   = 3'd0;
    localparam logic [2:0] HDR_WORD_FRAG  = 3'd1;
    localparam logic [2:0] HDR_WORD_PROTO = 3'd2;
    localparam logic [2:0] HDR_WORD_SRC   = 3'd3;
    localparam logic [2:0] HDR_WORD_DST   = 3'd4;
    localparam logic [2:0] HDR_WORD_PORTS = 3'd5;
    localparam logic [2:0] HDR_WORD_ULEN  = 3'd6;

endpackage

// File: rtl/ip_hdr_csum.sv
// IPv4 header checksum: 18-bit end-around-carry accumulator with a double fold.
// pass reflects the sum including the word presented in the current cycle.
module ip_hdr_csum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        add,
    input  logic [31:0] word,
    output logic        pass
);

    logic [17:0] acc_q, acc_d, base;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Carries are folded back on every add so five words never overflow 18 bits.
    always_comb begin
        base  = clear ? 18'd0 : ({2'b00, acc_q[15:0]} + {16'd0, acc_q[17:16]});
        acc_d = base + {2'b00, word[31:16]} + {2'b00, word[15:0]};
        fold1 = {1'b0, acc_d[15:0]} + {15'd0, acc_d[17:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        pass  = (fold2 == 16'hFFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (add) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/udp_ip_rx.sv
// Receive-side UDP/IPv4 parser: validates headers and streams the payload.
// Define UDP_RX_STATS_EN to add saturating good/drop datagram counters.
module udp_ip_rx
    import udp_ip_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           local_ip,
    input  logic [15:0]           local_port,
    input  logic [DATA_WIDTH-1:0] mac_rx_data,
    input  logic                  mac_rx_valid,
    input  logic                  mac_rx_sof,
    input  logic                  mac_rx_last,
    output logic [DATA_WIDTH-1:0] app_data,
    output logic                  app_valid,
    output logic                  app_last,
    output logic [1:0]            app_bytes,
    output logic                  app_err,
    output logic [15:0]           app_len,
    output logic [31:0]           rx_src_ip,
    output logic [15:0]           rx_src_port,
`ifdef UDP_RX_STATS_EN
    output logic [CNT_WIDTH-1:0]  rx_good_cnt,
    output logic [CNT_WIDTH-1:0]  rx_drop_cnt,
`endif
    output logic                  rx_drop
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d, cur_idx;
    logic [15:0] tot_len_q, tot_len_d, hdr_len_q, hdr_len_d, rem_q, rem_d, ulen;
    logic [31:0] hdr_src_ip_q, hdr_src_ip_d;
    logic [15:0] hdr_src_port_q, hdr_src_port_d;
    logic        first_q, first_d;
    logic [31:0] app_data_q, app_data_d, src_ip_q, src_ip_d;
    logic        app_valid_q, app_valid_d, app_last_q, app_last_d, app_err_q, app_err_d;
    logic [1:0]  app_bytes_q, app_bytes_d;
    logic [15:0] app_len_q, app_len_d, src_port_q, src_port_d;
    logic        drop_q, drop_d;
    logic        hdr_word, hdr_fail, csum_add, csum_pass, good_evt;

    // A sof word always restarts parsing at word 0, whatever the current state.
    assign hdr_word = mac_rx_valid &&
                      (mac_rx_sof || (state_q == StHdr && idx_q != 3'd0) || state_q == StUdp);
    assign cur_idx  = mac_rx_sof ? HDR_WORD_VER : idx_q;
    assign csum_add = hdr_word && (cur_idx <= HDR_WORD_DST);
    assign ulen     = mac_rx_data[31:16];

    ip_hdr_csum u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mac_rx_valid && mac_rx_sof),
        .add   (csum_add),
        .word  (mac_rx_data),
        .pass  (csum_pass)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tot_len_d      = tot_len_q;
        hdr_len_d      = hdr_len_q;
        rem_d          = rem_q;
        hdr_src_ip_d   = hdr_src_ip_q;
        hdr_src_port_d = hdr_src_port_q;
        first_d        = first_q;
        app_data_d     = '0;
        app_valid_d    = 1'b0;
        app_last_d     = 1'b0;
        app_bytes_d    = 2'd0;
        app_err_d      = 1'b0;
        app_len_d      = app_len_q;
        src_ip_d       = src_ip_q;
        src_port_d     = src_port_q;
        drop_d         = 1'b0;
        hdr_fail       = 1'b0;
        good_evt       = 1'b0;

        if (mac_rx_valid) begin
            // Close an outstanding datagram before the new frame is parsed.
            if (mac_rx_sof && state_q == StPayload) begin
                app_valid_d = 1'b1;
                app_last_d  = 1'b1;
                app_err_d   = 1'b1;
            end

            if (hdr_word) begin
                case (cur_idx)
                    HDR_WORD_VER: begin
                        hdr_fail  = mac_rx_data[31:28] != IP_VERSION ||
                                    mac_rx_data[27:24] != IP_IHL_MIN ||
                                    mac_rx_data[15:0] < IP_MIN_TOTAL;
                        tot_len_d = mac_rx_data[15:0];
                    end
                    HDR_WORD_FRAG:  hdr_fail = mac_rx_data[13:0] != 14'd0;
                    HDR_WORD_PROTO: hdr_fail = mac_rx_data[23:16] != IP_PROTO_UDP;
                    HDR_WORD_SRC:   hdr_src_ip_d = mac_rx_data;
                    HDR_WORD_DST:   hdr_fail = mac_rx_data != local_ip || !csum_pass;
                    HDR_WORD_PORTS: begin
                        hdr_fail       = mac_rx_data[15:0] != local_port;
                        hdr_src_port_d = mac_rx_data[31:16];
                    end
                    HDR_WORD_ULEN:  hdr_fail = ulen < UDP_HDR_BYTES ||
                                               ulen > tot_len_q - IP_HDR_BYTES;
                    default: ;
                endcase

                idx_d = 3'd0;
                if (hdr_fail) begin
                    drop_d  = 1'b1;
                    state_d = mac_rx_last ? StHdr : StDrop;
                end else if (cur_idx == HDR_WORD_ULEN && ulen == UDP_HDR_BYTES) begin
                    good_evt = 1'b1;
                    state_d  = mac_rx_last ? StHdr : StDrop;
                end else if (mac_rx_last) begin
                    drop_d  = 1'b1;
                    state_d = StHdr;
                end else if (cur_idx == HDR_WORD_ULEN) begin
                    rem_d     = ulen - UDP_HDR_BYTES;
                    hdr_len_d = ulen - UDP_HDR_BYTES;
                    first_d   = 1'b1;
                    state_d   = StPayload;
                end else begin
                    idx_d   = cur_idx + 3'd1;
                    state_d = (cur_idx >= HDR_WORD_DST) ? StUdp : StHdr;
                end
            end else if (state_q == StPayload) begin
                app_valid_d = 1'b1;
                app_data_d  = mac_rx_data;
                if (first_q) begin
                    app_len_d  = hdr_len_q;
                    src_ip_d   = hdr_src_ip_q;
                    src_port_d = hdr_src_port_q;
                    first_d    = 1'b0;
                end
                if (rem_q <= 16'd4) begin
                    app_last_d  = 1'b1;
                    app_bytes_d = rem_q[1:0];
                    good_evt    = 1'b1;
                    state_d     = mac_rx_last ? StHdr : StDrop;
                end else if (mac_rx_last) begin
                    app_last_d = 1'b1;
                    app_err_d  = 1'b1;
                    state_d    = StHdr;
                end else begin
                    rem_d = rem_q - 16'd4;
                end
            end else if (state_q == StDrop && mac_rx_last) begin
                state_d = StHdr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StHdr;
            idx_q          <= '0;
            tot_len_q      <= '0;
            hdr_len_q      <= '0;
            rem_q          <= '0;
            hdr_src_ip_q   <= '0;
            hdr_src_port_q <= '0;
            first_q        <= 1'b0;
            app_data_q     <= '0;
            app_valid_q    <= 1'b0;
            app_last_q     <= 1'b0;
            app_bytes_q    <= '0;
            app_err_q      <= 1'b0;
            app_len_q      <= '0;
            src_ip_q       <= '0;
            src_port_q     <= '0;
            drop_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tot_len_q      <= tot_len_d;
            hdr_len_q      <= hdr_len_d;
            rem_q          <= rem_d;
            hdr_src_ip_q   <= hdr_src_ip_d;
            hdr_src_port_q <= hdr_src_port_d;
            first_q        <= first_d;
            app_data_q     <= app_data_d;
            app_valid_q    <= app_valid_d;
            app_last_q     <= app_last_d;
            app_bytes_q    <= app_bytes_d;
            app_err_q      <= app_err_d;
            app_len_q      <= app_len_d;
            src_ip_q       <= src_ip_d;
            src_port_q     <= src_port_d;
            drop_q         <= drop_d;
        end
    end

    assign app_data    = app_data_q;
    assign app_valid   = app_valid_q;
    assign app_last    = app_last_q;
    assign app_bytes   = app_bytes_q;
    assign app_err     = app_err_q;
    assign app_len     = app_len_q;
    assign rx_src_ip   = src_ip_q;
    assign rx_src_port = src_port_q;
    assign rx_drop     = drop_q;

`ifdef UDP_RX_STATS_EN
    logic [CNT_WIDTH-1:0] good_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (good_evt && good_cnt_q != '1) good_cnt_q <= good_cnt_q + 1'b1;
            if ((drop_d || app_err_d) && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign rx_good_cnt = good_cnt_q;
    assign rx_drop_cnt = drop_cnt_q;
`else
    logic [CNT_WIDTH-1:0] unused_stats;
    assign unused_stats = {CNT_WIDTH{good_evt}};
`endif

endmodule

// File: tb/tb_udp_ip_rx.sv
// Directed bench for udp_ip_rx: hand-built IPv4/UDP frames with known results.
module tb_udp_ip_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] local_ip = 32'hC0A80102;
    logic [15:0] local_port = 16'd12346;
    logic [31:0] mac_rx_data = '0;
    logic        mac_rx_valid = 1'b0, mac_rx_sof = 1'b0, mac_rx_last = 1'b0;
    logic [31:0] app_data;
    logic        app_valid, app_last, app_err, rx_drop;
    logic [1:0]  app_bytes;
    logic [15:0] app_len, rx_src_port;
    logic [31:0] rx_src_ip;
`ifdef UDP_RX_STATS_EN
    logic [15:0] rx_good_cnt, rx_drop_cnt;
`endif

    int checks = 0, errors = 0, beats = 0, drops = 0;
    logic [31:0] frm [0:7];

    always #4 clk = ~clk;

    udp_ip_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .local_ip     (local_ip),
        .local_port   (local_port),
        .mac_rx_data  (mac_rx_data),
        .mac_rx_valid (mac_rx_valid),
        .mac_rx_sof   (mac_rx_sof),
        .mac_rx_last  (mac_rx_last),
        .app_data     (app_data),
        .app_valid    (app_valid),
        .app_last     (app_last),
        .app_bytes    (app_bytes),
        .app_err      (app_err),
        .app_len      (app_len),
        .rx_src_ip    (rx_src_ip),
        .rx_src_port  (rx_src_port),
`ifdef UDP_RX_STATS_EN
        .rx_good_cnt  (rx_good_cnt),
        .rx_drop_cnt  (rx_drop_cnt),
`endif
        .rx_drop      (rx_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one word, then sample the registered result 1 ns after the edge.
    task automatic send(input logic [31:0] w, input logic sof, input logic last);
        mac_rx_data  = w;
        mac_rx_valid = 1'b1;
        mac_rx_sof   = sof;
        mac_rx_last  = last;
        @(posedge clk);
        #1;
        mac_rx_valid = 1'b0;
        mac_rx_sof   = 1'b0;
        mac_rx_last  = 1'b0;
        beats += int'(app_valid);
        drops += int'(rx_drop);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            beats += int'(app_valid);
            drops += int'(rx_drop);
        end
    endtask

    task automatic load_good();
        frm[0] = 32'h45000020; frm[1] = 32'h00004000; frm[2] = 32'h4011B779;
        frm[3] = 32'hC0A80101; frm[4] = 32'hC0A80102; frm[5] = 32'h3039303A;
        frm[6] = 32'h000C0000; frm[7] = 32'hDEADBEEF;
    endtask

    // Sends frm[first..7], with gap idle cycles between words; sof only on word 0.
    task automatic send_frm(input int first, input int gap);
        for (int i = first; i < 8; i++) begin
            send(frm[i], i == 0, i == 7);
            if (i != 7) idle(gap);
        end
    endtask

    task automatic check_good_beat(input string tag);
        check({tag, " data"}, app_data, 32'hDEADBEEF);
        check({tag, " valid/last/err/bytes"}, {27'd0, app_valid, app_last, app_err, app_bytes},
              {27'd0, 1'b1, 1'b1, 1'b0, 2'd0});
        check({tag, " len"}, {16'd0, app_len}, 32'd4);
        check({tag, " src_ip"}, rx_src_ip, 32'hC0A80101);
        check({tag, " src_port"}, {16'd0, rx_src_port}, 32'd12345);
    endtask

    initial begin
        // Reset state
        idle(3);
        check("reset app_valid/last/err/drop", {28'd0, app_valid, app_last, app_err, rx_drop}, 32'd0);
        check("reset app_data", app_data, 32'd0);
        check("reset app_len/src_port", {app_len, rx_src_port}, 32'd0);
        check("reset rx_src_ip", rx_src_ip, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Valid frame, single 4-byte payload word
        beats = 0; drops = 0;
        load_good();
        send_frm(0, 0);
        check_good_beat("good");
        idle(2);
        check("good beats", beats, 1);
        check("good drops", drops, 0);

        // Bad header checksum: drop pulse right after word 4
        beats = 0; drops = 0;
        load_good();
        frm[2] = 32'h4011B778;
        for (int i = 0; i < 5; i++) send(frm[i], i == 0, 1'b0);
        check("csum drop pulse", {31'd0, rx_drop}, 32'd1);
        for (int i = 5; i < 8; i++) send(frm[i], 1'b0, i == 7);
        idle(2);
        check("csum beats", beats, 0);
        check("csum drops", drops, 1);

        // Wrong destination port, then a good frame with idle gaps
        beats = 0; drops = 0;
        load_good();
        frm[5] = 32'h3039303B;
        for (int i = 0; i < 6; i++) send(frm[i], i == 0, 1'b0);
        check("port drop pulse", {31'd0, rx_drop}, 32'd1);
        send(frm[6], 1'b0, 1'b0);
        send(frm[7], 1'b0, 1'b1);
        load_good();
        send_frm(0, 2);
        check_good_beat("after port");
        check("port drops", drops, 1);

        // Protocol 6: rejected at word 2
        beats = 0; drops = 0;
        load_good();
        frm[2] = 32'h4006B784;
        for (int i = 0; i < 3; i++) send(frm[i], i == 0, 1'b0);
        check("proto drop pulse", {31'd0, rx_drop}, 32'd1);
        for (int i = 3; i < 8; i++) send(frm[i], 1'b0, i == 7);
        load_good();
        send_frm(0, 0);
        check_good_beat("after proto");
        check("proto beats/drops", {beats[15:0], drops[15:0]}, {16'd1, 16'd1});

        // 3-byte payload followed by three words of Ethernet padding
        beats = 0; drops = 0;
        load_good();
        frm[0] = 32'h4500001F; frm[2] = 32'h4011B77A; frm[6] = 32'h000B0000;
        for (int i = 0; i < 7; i++) send(frm[i], i == 0, 1'b0);
        send(32'hAABBCC00, 1'b0, 1'b0);
        check("pad beat", {26'd0, app_valid, app_last, app_err, 1'b0, app_bytes},
              {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3});
        check("pad len", {16'd0, app_len}, 32'd3);
        send(32'h0, 1'b0, 1'b0);
        send(32'h0, 1'b0, 1'b0);
        send(32'h0, 1'b0, 1'b1);
        idle(2);
        check("pad beats/drops", {beats[15:0], drops[15:0]}, {16'd1, 16'd0});

        // Truncated datagram: last arrives on the first of two payload words
        load_good();
        frm[0] = 32'h45000024; frm[2] = 32'h4011B775; frm[6] = 32'h00100000;
        for (int i = 0; i < 7; i++) send(frm[i], i == 0, 1'b0);
        send(32'h11223344, 1'b0, 1'b1);
        check("trunc data", app_data, 32'h11223344);
        check("trunc last/err/bytes", {27'd0, app_valid, app_last, app_err, app_bytes},
              {27'd0, 1'b1, 1'b1, 1'b1, 2'd0});
        check("trunc len", {16'd0, app_len}, 32'd8);
        idle(2);

        // sof mid-payload: abort beat, then the new frame parses normally
        for (int i = 0; i < 7; i++) send(frm[i], i == 0, 1'b0);
        send(32'h11223344, 1'b0, 1'b0);
        check("pre-abort beat", {30'd0, app_valid, app_last}, {30'd0, 1'b1, 1'b0});
        load_good();
        send(frm[0], 1'b1, 1'b0);
        check("abort beat", {29'd0, app_valid, app_last, app_err}, {29'd0, 3'b111});
        check("abort data", app_data, 32'd0);
        send_frm(1, 0);
        check_good_beat("after abort");

        // Asynchronous reset mid-payload
        load_good();
        frm[0] = 32'h45000024; frm[2] = 32'h4011B775; frm[6] = 32'h00100000;
        for (int i = 0; i < 7; i++) send(frm[i], i == 0, 1'b0);
        send(32'h55667788, 1'b0, 1'b0);
        check("pre-reset len", {16'd0, app_len}, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset valid/drop", {30'd0, app_valid, rx_drop}, 32'd0);
        check("mid reset len/port", {app_len, rx_src_port}, 32'd0);
        check("mid reset src_ip", rx_src_ip, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beats = 0; drops = 0;
        send(32'h99AABBCC, 1'b0, 1'b1);
        send(32'h45000020, 1'b0, 1'b0);
        send(32'h00004000, 1'b0, 1'b1);
        idle(2);
        check("post reset ignored", {beats[15:0], drops[15:0]}, 32'd0);
        load_good();
        send_frm(0, 0);
        check_good_beat("post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
